// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle controller and PC owner for the RV32 datapath. Each
//   instruction is walked through FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
//   with ready handshakes on both memories. Illegal opcodes park the FSM in
//   a sticky TRAP state that only reset leaves.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ins, imem_ready         instruction-memory data and data-valid
//   dmem_ready              data-memory access complete
//   zero, imm, jtarget      ALU zero flag, immediate, jump offset
//   pc, ir                  current PC and latched instruction
//   imem_req, dmem_req      memory requests
//   reg_write, alu_src, mem2reg, mem_read, mem_write, alu_op
//                           datapath controls
//   trap, state             sticky illegal-opcode flag, FSM state (debug)
//   cycle_cnt, retire_cnt   wrapping performance counters
module multicycle_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'('h28),
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             zero,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] jtarget,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      ir,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem2reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       alu_op,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    state_t           state_q;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_r, is_load, is_store, is_branch, is_jal, legal;
    logic [2:0]       op_dec;
    logic [WIDTH-1:0] pc_next;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign is_r      = (opcode == OP_R);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign legal     = is_r | is_load | is_store | is_branch | is_jal |
                       (opcode == OP_I);

    assign state = state_q;

    // ALU operation decoded from the latched instruction.
    always_comb begin
        op_dec = 3'b010;
        if (is_branch) begin
            op_dec = 3'b110;
        end else if (is_r) begin
            if (ir[30] && funct3 == 3'd0) op_dec = 3'b110;
            else if (funct3 == 3'd7)      op_dec = 3'b000;
            else if (funct3 == 3'd6)      op_dec = 3'b001;
            else                          op_dec = 3'b010;
        end
    end

    // Next PC; only committed on the edge that retires the instruction.
    always_comb begin
        pc_next = pc + WIDTH'(4);
        if (is_branch && zero) pc_next = pc + (imm << 1);
        else if (is_jal)       pc_next = pc + (jtarget << 2);
    end

    // Controls are a pure decode of the state register and ir, so the
    // asynchronous reset of the state drops them immediately. imem_req is
    // additionally gated by rst_n because FETCH is also the reset state.
    assign imem_req = (state_q == S_FETCH) & rst_n;

    always_comb begin
        dmem_req  = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        mem2reg   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = 3'b000;
        case (state_q)
            S_EXEC: begin
                alu_src = ~(is_r | is_branch);
                alu_op  = op_dec;
            end
            S_MEM: begin
                alu_src   = 1'b1;
                alu_op    = op_dec;
                dmem_req  = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
            end
            S_WB: begin
                alu_src   = ~is_r;
                alu_op    = op_dec;
                reg_write = 1'b1;
                mem2reg   = is_load;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            ir         <= 32'd0;
            pc         <= RESET_PC;
            trap       <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir      <= ins;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        trap    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        pc         <= pc_next;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                        state_q    <= S_FETCH;
                    end else if (is_load || is_store) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (is_load) begin
                            state_q <= S_WB;
                        end else begin
                            pc         <= pc_next;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc         <= pc_next;
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    state_q    <= S_FETCH;
                end
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ins = 32'd0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] jtarget = 32'd0;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        imem_req, dmem_req, reg_write, alu_src, mem2reg, mem_read, mem_write;
    logic [2:0]  alu_op;
    logic        trap;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, retire_cnt;

    multicycle_ctrl #(.WIDTH(32), .RESET_PC(32'h28), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .zero(zero), .imm(imm), .jtarget(jtarget),
        .pc(pc), .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req),
        .reg_write(reg_write), .alu_src(alu_src), .mem2reg(mem2reg),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
        .trap(trap), .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        zero;
        logic [31:0] imm;
        logic [31:0] jt;
        int          iwait;
        int          dwait;
        logic [2:0]  exp_op;
        logic        exp_src;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          cycles;
        int          rw;
        int          mr;
        int          mw;
        int          m2r;
    } exp_t;

    vec_t        vecs[14];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cyc;
    logic [31:0] model_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v, input logic [31:0] cur_pc);
        exp_t       e;
        logic [6:0] opc;
        int         base;
        opc  = v.ins[6:0];
        base = 4;
        if (opc == 7'h03) base = 5;
        if (opc == 7'h63) base = 3;
        e.cycles = base + v.iwait + ((opc == 7'h03 || opc == 7'h23) ? v.dwait : 0);
        if (opc == 7'h63 && v.zero)  e.pc = cur_pc + (v.imm << 1);
        else if (opc == 7'h6F)       e.pc = cur_pc + (v.jt << 2);
        else                         e.pc = cur_pc + 32'd4;
        e.rw  = (opc == 7'h23 || opc == 7'h63) ? 0 : 1;
        e.mr  = (opc == 7'h03) ? v.dwait + 1 : 0;
        e.mw  = (opc == 7'h23) ? v.dwait + 1 : 0;
        e.m2r = (opc == 7'h03) ? 1 : 0;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ins = 32'd0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pc", pc, 32'h28);
            chk("rst_imem_req", imem_req, 0);
            chk("rst_cycle_cnt", cycle_cnt, 0);
            chk("rst_retire_cnt", retire_cnt, 0);
            chk("rst_state", state, 0);
            chk("rst_trap", trap, 0);
            chk("rst_ctrls", {dmem_req, reg_write, mem_read, mem_write, mem2reg}, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_imem_req", imem_req, 1);
        model_pc  = 32'h28;
        model_cyc = 32'd0;
        model_ret = 32'd0;
    endtask

    task automatic run_instr(input string tag, input vec_t v);
        exp_t        e, got;
        int          cyc, iw, dw, rw, mr, mw, m2r;
        logic [2:0]  op_seen;
        logic        src_seen;
        logic [31:0] r0;
        bit          done;
        exp_q.push_back(model(v, model_pc));
        ins = v.ins; zero = v.zero; imm = v.imm; jtarget = v.jt;
        cyc = 0; iw = 0; dw = 0; rw = 0; mr = 0; mw = 0; m2r = 0;
        op_seen = 3'bxxx; src_seen = 1'bx; done = 0;
        r0 = retire_cnt;
        while (!done && cyc < 60) begin
            if (state == 3'd2) begin
                op_seen  = alu_op;
                src_seen = alu_src;
            end
            rw += int'(reg_write); mr += int'(mem_read);
            mw += int'(mem_write); m2r += int'(mem2reg);
            imem_ready = 1'b1;
            if (state == 3'd0 && iw < v.iwait) begin imem_ready = 1'b0; iw++; end
            dmem_ready = 1'b1;
            if (state == 3'd3 && dw < v.dwait) begin dmem_ready = 1'b0; dw++; end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (retire_cnt != r0) done = 1;
        end
        if (!done || exp_q.size() == 0) begin
            chk({tag, "_timeout"}, 1, 0);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            got.pc = pc; got.cycles = cyc;
            model_pc  = e.pc;
            model_cyc = model_cyc + 32'(e.cycles);
            model_ret = model_ret + 32'd1;
            chk({tag, "_pc"}, got.pc, e.pc);
            chk({tag, "_cycles"}, got.cycles, e.cycles);
            chk({tag, "_alu_op"}, op_seen, v.exp_op);
            chk({tag, "_alu_src"}, src_seen, v.exp_src);
            chk({tag, "_reg_write_cycles"}, rw, e.rw);
            chk({tag, "_mem_read_cycles"}, mr, e.mr);
            chk({tag, "_mem_write_cycles"}, mw, e.mw);
            chk({tag, "_mem2reg_cycles"}, m2r, e.m2r);
            chk({tag, "_retire_cnt"}, retire_cnt, model_ret);
            chk({tag, "_cycle_cnt"}, cycle_cnt, model_cyc);
            chk({tag, "_state"}, state, 0);
        end
    endtask

    initial begin
        vec_t v;
        //          ins            z  imm            jt     iw dw op      src
        vecs[0]  = '{32'h002081B3, 0, 32'd0,         32'd0, 0, 0, 3'b010, 1'b0};
        vecs[1]  = '{32'h402081B3, 0, 32'd0,         32'd0, 0, 0, 3'b110, 1'b0};
        vecs[2]  = '{32'h0020F1B3, 0, 32'd0,         32'd0, 0, 0, 3'b000, 1'b0};
        vecs[3]  = '{32'h0020E1B3, 0, 32'd0,         32'd0, 0, 0, 3'b001, 1'b0};
        vecs[4]  = '{32'h0020C1B3, 0, 32'd0,         32'd0, 0, 0, 3'b010, 1'b0};
        vecs[5]  = '{32'h40108093, 0, 32'd0,         32'd0, 0, 0, 3'b010, 1'b1};
        vecs[6]  = '{32'h0000A183, 0, 32'd0,         32'd0, 0, 3, 3'b010, 1'b1};
        vecs[7]  = '{32'h0030A023, 0, 32'd0,         32'd0, 0, 0, 3'b010, 1'b1};
        vecs[8]  = '{32'h00000063, 1, 32'd4,         32'd0, 0, 0, 3'b110, 1'b0};
        vecs[9]  = '{32'h00000063, 0, 32'd4,         32'd0, 0, 0, 3'b110, 1'b0};
        vecs[10] = '{32'h0000006F, 0, 32'd0,         32'd5, 0, 0, 3'b010, 1'b1};
        vecs[11] = '{32'h002081B3, 0, 32'd0,         32'd0, 2, 0, 3'b010, 1'b0};
        vecs[12] = '{32'h00000063, 1, 32'hFFFFFFFE,  32'd0, 1, 0, 3'b110, 1'b0};
        vecs[13] = '{32'h0030A023, 0, 32'd0,         32'd0, 1, 2, 3'b010, 1'b1};

        #2;
        do_reset();

        // Test-plan R-type add from reset: pc 0x2C, cycle_cnt 4, retire 1.
        run_instr("radd_first", vecs[0]);
        chk("radd_first_pc_abs", pc, 32'h2C);
        chk("radd_first_cyc_abs", cycle_cnt, 4);

        // Slow load from a fresh reset: 8 cycles, pc 0x2C.
        do_reset();
        run_instr("load_slow", vecs[6]);
        chk("load_slow_pc_abs", pc, 32'h2C);
        chk("load_slow_cyc_abs", cycle_cnt, 8);

        // Taken branch from reset: 0x28 -> 0x30 in 3 cycles.
        do_reset();
        run_instr("br_taken", vecs[8]);
        chk("br_taken_pc_abs", pc, 32'h30);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            run_instr($sformatf("v%0d", i), v);
        end

        // Illegal opcode: trap after DECODE, then frozen.
        ins = 32'h0000007F;
        imem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ill_state_decode", state, 1);
        @(posedge clk); @(negedge clk);
        chk("ill_state_trap", state, 5);
        chk("ill_trap", trap, 1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("ill_imem_req_%0d", i), imem_req, 0);
            chk($sformatf("ill_pc_%0d", i), pc, model_pc);
            chk($sformatf("ill_cyc_%0d", i), cycle_cnt, model_cyc + 32'd2);
            chk($sformatf("ill_ctrl_%0d", i), {dmem_req, reg_write, mem_read, mem_write, alu_op}, 0);
            @(posedge clk); @(negedge clk);
        end
        chk("ill_still_trap", state, 5);
        do_reset();
        chk("ill_recover_trap", trap, 0);
        run_instr("after_trap", vecs[0]);

        // Reset asserted mid-store with the data memory stalled.
        do_reset();
        ins = 32'h0030A023;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("st_rst_state_mem", state, 3);
        chk("st_rst_dmem_req_hi", dmem_req, 1);
        chk("st_rst_mem_write_hi", mem_write, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("st_rst_dmem_req_lo", dmem_req, 0);
        chk("st_rst_mem_write_lo", mem_write, 0);
        chk("st_rst_reg_write_lo", reg_write, 0);
        chk("st_rst_pc", pc, 32'h28);
        chk("st_rst_retire", retire_cnt, 0);
        chk("st_rst_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Multi-cycle controller and PC owner for the RV32 datapath (yIF/yID/yEX/yDM/yWB).
- Replaces the per-instruction ad-hoc control settings with a registered FSM.
- Sequences each instruction through fetch, decode, execute, memory and writeback, with ready handshakes on both memories.
- Drives every datapath control line, computes the next PC, flags illegal opcodes, and keeps cycle and retired-instruction counters.

## Interface

Parameters:
- WIDTH, 32, PC/imm/jtarget width.
- RESET_PC, 'h28, PC value after reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- ins  in  32  instruction-memory read data.
- imem_ready  in  1  instruction-memory data valid.
- dmem_ready  in  1  data-memory access complete.
- zero  in  1  ALU zero flag from yEX.
- imm  in  WIDTH  sign-extended immediate from yID.
- jtarget  in  WIDTH  jump offset from yID.
- pc  out  WIDTH  current PC, fed to yIF.
- ir  out  32  latched instruction.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data access request.
- reg_write, alu_src, mem2reg, mem_read, mem_write  out  1 each  datapath controls.
- alu_op  out  3  ALU operation.
- trap  out  1  sticky illegal-opcode flag.
- state  out  3  FSM state, for debug.
- cycle_cnt, retire_cnt  out  CNT_W  performance counters.

## Operation

State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

- **FETCH:** imem_req=1. On imem_ready, latch ins into ir and go to DECODE. Otherwise stay in FETCH.
- **DECODE:** opcode=ir[6:0].
  - Legal opcodes: 0x33 (R), 0x13 (I-ALU), 0x03 (load), 0x23 (store), 0x63 (branch), 0x6F (jal).
  - Legal opcode goes to EXEC; any other opcode goes to TRAP.
- **EXEC:** alu_src=1 for every opcode except 0x33 and 0x63.
  - Branch (0x63): the PC updates this cycle, retire increments, then go to FETCH.
  - Load/store: go to MEM.
  - Others: go to WB.
- **MEM:** dmem_req=1; mem_read=1 for a load, mem_write=1 for a store. Both are held until dmem_ready.
  - Load: go to WB.
  - Store: PC updates, retire increments, go to FETCH.
- **WB:** reg_write=1 for exactly one cycle; mem2reg=1 for a load only.
  - PC updates, retire increments, go to FETCH.
- **TRAP:** trap=1 and all other controls are 0. Only reset exits TRAP.

alu_op:
- 3'b110 (sub) for branches.
- For R-type:
  - funct7[5]=1 with funct3=0 gives 3'b110.
  - funct3=7 gives 3'b000 (and).
  - funct3=6 gives 3'b001 (or).
  - Anything else gives 3'b010.
- 3'b010 (add) for all other opcodes.

Next PC (modulo 2^WIDTH):
- Branch with zero=1: pc + (imm << 1).
- jal: pc + (jtarget << 2).
- All other cases: pc + 4.

Other rules:
- All control outputs decode from the registered state and ir only.
- cycle_cnt increments every cycle outside TRAP. Both counters wrap silently.

## Timing

- Reset value of every output: pc=RESET_PC, ir=0, state=FETCH, trap=0, counters=0, and all controls/requests 0.
- While rst_n=0, imem_req is forced to 0 (imem_req = FETCH & rst_n).
- Reset asserted mid-operation clears the state asynchronously, so dmem_req, mem_write and reg_write drop within the same cycle.
- Latency with zero-wait memories (ready high on the first request cycle):
  - R/I/jal: 4 cycles.
  - Load: 5 cycles.
  - Store and branch: 4 and 3 cycles respectively.
- Each cycle that imem_ready or dmem_ready stays low adds one cycle.
- Handshake rules:
  - The request stays high until the cycle in which ready=1 is sampled.
  - A request drops on the cycle after that sample.
  - A ready received while no request is outstanding is ignored.
- pc changes only at the edge that leaves EXEC (branch), MEM (store) or WB. It is stable for yIF throughout FETCH.
- retire_cnt increments on that same edge.

## Test plan

- **Reset:** hold rst_n=0 for 3 cycles, then release.
  - While low: pc=0x28, imem_req=0, all counters 0.
  - After release: imem_req=1 on the first cycle.
- **R-type add:** ins=0x002081B3 with ready always 1.
  - States run FETCH, DECODE, EXEC, WB.
  - reg_write is high only in WB; alu_op=010.
  - Afterwards pc=0x2C, retire_cnt=1, cycle_cnt=4.
- **Load with slow data memory:** ins=0x0000A183, dmem_ready held low for 3 MEM cycles.
  - mem_read is high for 4 cycles.
  - mem2reg=1 and reg_write=1 in WB.
  - Total 8 cycles; pc ends at 0x2C.
- **Branch (opcode 0x63), imm=4:**
  - zero=1: pc goes 0x28 to 0x30 in 3 cycles with alu_op=110 and reg_write never high.
  - zero=0: pc goes to 0x2C.
- **Illegal opcode:** ins=0x0000007F.
  - After DECODE, state=TRAP and trap=1.
  - imem_req=0 for the next 20 cycles; pc and cycle_cnt are frozen.
  - Only rst_n recovers the block.
- **Reset during a store:** sw with dmem_ready=0, rst_n pulsed low while in MEM.
  - dmem_req and mem_write fall before the next clock edge.
  - pc=0x28, retire_cnt=0.
